// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC sample sequencer.
// The ADC_AVG_EN build option is consumed by adc_sample_ctrl.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } adc_state_t;

  localparam int AVG_COUNT = 4;

  // Cycles spent with chip select low for one conversion
  function automatic int conv_cycles(input int clkdiv, input int adc_bits);
    return 2 * clkdiv * adc_bits;
  endfunction

endpackage

// File: rtl/adc_fifo.sv
// First-word-fall-through sample buffer; head reads as zero when empty.
module adc_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Period-timed serial ADC sequencer feeding a FWFT sample FIFO.
// Define ADC_AVG_EN to push the mean of every four conversions instead of each one.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int ADC_BITS   = 12,
  parameter int CLKDIV     = 4,
  parameter int PERIOD     = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_sdo,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] adcdata,
  output logic              data_valid,
  output logic              overrun,
  input  logic              clr_ovr,
  output logic              busy
);

  localparam int TW = $clog2(PERIOD);
  localparam int DW = $clog2(CLKDIV + 1);
  localparam int HW = $clog2(2 * ADC_BITS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLKDIV - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(2 * ADC_BITS - 1);

  adc_state_t        state;
  adc_state_t        next_state;
  logic [TW-1:0]     timer;
  logic              tick;
  logic [DW-1:0]     div_cnt;
  logic [HW-1:0]     half_cnt;
  logic              half_end;
  logic [ADC_BITS-1:0] shreg;
  logic              conv_done;
  logic              push;
  logic [ADC_BITS-1:0] push_data;
  logic [ADC_BITS-1:0] head;
  logic              full;
  logic              empty;
  logic              ovr_set;

  assign tick     = enable && (timer == TIMER_LAST);
  assign half_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                timer <= '0;
    else if (!enable || tick)  timer <= '0;
    else                       timer <= timer + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick) next_state = SHIFT;
      SHIFT:   if (half_end && (half_cnt == HALF_LAST)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    adc_cs_n  = 1'b1;
    busy      = 1'b0;
    conv_done = 1'b0;
    case (state)
      SHIFT: begin
        adc_cs_n = 1'b0;
        busy     = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        conv_done = 1'b1;
      end
      default: ;
    endcase
  end

  // sclk starts low; data is captured on the same edge that drives sclk high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      adc_sclk <= 1'b0;
      shreg    <= '0;
    end else if (state == SHIFT) begin
      if (half_end) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 1'b1;
        adc_sclk <= ~adc_sclk;
        if (!adc_sclk) shreg <= {shreg[ADC_BITS-2:0], adc_sdo};
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      div_cnt  <= '0;
      half_cnt <= '0;
      adc_sclk <= 1'b0;
    end
  end

`ifdef ADC_AVG_EN
  logic [ADC_BITS+1:0] acc;
  logic [ADC_BITS+1:0] sum;
  logic [1:0]          avg_cnt;

  assign sum       = acc + {2'b00, shreg};
  assign push      = conv_done && (avg_cnt == 2'(AVG_COUNT - 1));
  assign push_data = sum[ADC_BITS+1:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      avg_cnt <= '0;
    end else if (conv_done) begin
      if (avg_cnt == 2'(AVG_COUNT - 1)) begin
        acc     <= '0;
        avg_cnt <= '0;
      end else begin
        acc     <= sum;
        avg_cnt <= avg_cnt + 1'b1;
      end
    end
  end
`else
  assign push      = conv_done;
  assign push_data = shreg;
`endif

  adc_fifo #(
    .WIDTH (ADC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (rd_en),
    .din   (push_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // A simultaneous pop makes room, so only an unserviced full push is a drop
  assign ovr_set = push && full && !rd_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        overrun <= 1'b0;
    else if (ovr_set)  overrun <= 1'b1;
    else if (clr_ovr)  overrun <= 1'b0;
  end

  assign adcdata    = {{(DWIDTH - ADC_BITS){1'b0}}, head};
  assign data_valid = !empty;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with a serial ADC model driving MSB-first data.
// Define ADC_AVG_EN to exercise the four-sample averaging build instead of the default one.
module tb_adc_sample_ctrl;
  import adc_pkg::*;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_sdo;
  logic        rd_en;
  logic [31:0] adcdata;
  logic        data_valid;
  logic        overrun;
  logic        clr_ovr;
  logic        busy;

  logic [11:0] adc_word;
  int          bit_idx = 11;
  logic        prev_sclk = 1'b0;

  int tests_run = 0;
  int failures  = 0;

  adc_sample_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_sdo    (adc_sdo),
    .rd_en      (rd_en),
    .adcdata    (adcdata),
    .data_valid (data_valid),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ADC model: MSB presented when cs_n falls, next bit after each sclk falling edge
  always @(adc_cs_n or adc_sclk or adc_word) begin
    if (adc_cs_n !== 1'b0) bit_idx = 11;
    else if (prev_sclk === 1'b1 && adc_sclk === 1'b0 && bit_idx > 0) bit_idx--;
    prev_sclk = adc_sclk;
    adc_sdo = adc_word[bit_idx];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rd, input logic clr);
    enable  = en;
    rd_en   = rd;
    clr_ovr = clr;
  endtask

  task automatic waitBusy(input int budget, input string tag, output int cycles);
    cycles = 0;
    while (busy !== 1'b1 && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    checkBit(tag, busy, 1'b1);
  endtask

  task automatic waitCsHigh(input int budget, input string tag);
    int n;
    n = 0;
    while (adc_cs_n !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkBit(tag, adc_cs_n, 1'b1);
  endtask

  // Runs one conversion of word; ends on the cycle after DONE
  task automatic runSample(input logic [11:0] word, input logic pop_on_done);
    int n;
    adc_word = word;
    waitBusy(1100, "conv_start", n);
    waitCsHigh(200, "conv_end");
    if (pop_on_done) rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  task automatic popExpect(input string tag, input logic [31:0] expected);
    checkOutput(tag, adcdata, expected);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  initial begin
    int n;
    int low_cycles;
    int pulses;
    int idle_low;
    logic last_sclk;

    reset    = 1'b0;
    adc_word = 12'h000;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    checkBit("rst_cs_n", adc_cs_n, 1'b1);
    checkBit("rst_sclk", adc_sclk, 1'b0);
    checkOutput("rst_adcdata", adcdata, 32'h0);
    checkBit("rst_valid", data_valid, 1'b0);
    checkBit("rst_overrun", overrun, 1'b0);
    checkBit("rst_busy", busy, 1'b0);

    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      checkBit("idle_cs_n", adc_cs_n, 1'b1);
      checkBit("idle_sclk", adc_sclk, 1'b0);
      checkBit("idle_valid", data_valid, 1'b0);
      checkOutput("idle_adcdata", adcdata, 32'h0);
    end

`ifdef ADC_AVG_EN
    applyStimulus(1'b1, 1'b0, 1'b0);
    runSample(12'd100, 1'b0);
    checkBit("avg_hold_1", data_valid, 1'b0);
    runSample(12'd200, 1'b0);
    checkBit("avg_hold_2", data_valid, 1'b0);
    runSample(12'd300, 1'b0);
    checkBit("avg_hold_3", data_valid, 1'b0);
    runSample(12'd401, 1'b0);
    checkBit("avg_valid", data_valid, 1'b1);
    popExpect("avg_mean", 32'd250);
    checkBit("avg_single_push", data_valid, 1'b0);
`else
    // First conversion: tick on the 999th cycle after enabling
    adc_word = 12'hA5C;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (999) @(negedge clock);
    checkBit("tick_cycle_cs_n", adc_cs_n, 1'b1);
    @(negedge clock);
    checkBit("t1_cs_n", adc_cs_n, 1'b0);
    checkBit("t1_busy", busy, 1'b1);
    checkBit("t1_sclk", adc_sclk, 1'b0);
    low_cycles = 0;
    pulses     = 0;
    last_sclk  = 1'b0;
    n          = 0;
    do begin
      if (adc_cs_n === 1'b0) low_cycles++;
      if (adc_sclk === 1'b1 && last_sclk === 1'b0) pulses++;
      last_sclk = adc_sclk;
      @(negedge clock);
      n++;
    end while (adc_cs_n === 1'b0 && n < 200);
    checkOutput("cs_low_cycles", low_cycles, conv_cycles(4, 12));
    checkOutput("sclk_pulses", pulses, 12);
    checkBit("done_busy", busy, 1'b1);
    checkBit("done_sclk", adc_sclk, 1'b0);
    checkBit("done_valid", data_valid, 1'b0);
    @(negedge clock);
    checkBit("t98_valid", data_valid, 1'b1);
    checkBit("t98_busy", busy, 1'b0);
    popExpect("first_sample", 32'h00000A5C);
    checkBit("popped_valid", data_valid, 1'b0);
    checkOutput("popped_adcdata", adcdata, 32'h0);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    checkBit("empty_pop_ignored", data_valid, 1'b0);

    // Overfill with no reads; clr_ovr held across the dropping push
    runSample(12'd1, 1'b0);
    runSample(12'd2, 1'b0);
    runSample(12'd3, 1'b0);
    runSample(12'd4, 1'b0);
    checkBit("full_no_ovr", overrun, 1'b0);
    clr_ovr = 1'b1;
    runSample(12'd5, 1'b0);
    checkBit("ovr_set_wins", overrun, 1'b1);
    clr_ovr = 1'b0;
    checkOutput("ovr_head", adcdata, 32'd1);
    popExpect("ovr_pop1", 32'd1);
    popExpect("ovr_pop2", 32'd2);
    popExpect("ovr_pop3", 32'd3);
    popExpect("ovr_pop4", 32'd4);
    checkBit("ovr_drained", data_valid, 1'b0);
    checkBit("ovr_sticky", overrun, 1'b1);
    clr_ovr = 1'b1;
    @(negedge clock);
    clr_ovr = 1'b0;
    checkBit("ovr_cleared", overrun, 1'b0);

    // Full FIFO with a pop on the DONE cycle
    runSample(12'd1, 1'b0);
    runSample(12'd2, 1'b0);
    runSample(12'd3, 1'b0);
    runSample(12'd4, 1'b0);
    runSample(12'd5, 1'b1);
    checkBit("pushpop_no_ovr", overrun, 1'b0);
    popExpect("pp_pop2", 32'd2);
    popExpect("pp_pop3", 32'd3);
    popExpect("pp_pop4", 32'd4);
    popExpect("pp_pop5", 32'd5);
    checkBit("pp_drained", data_valid, 1'b0);

    // Enable dropped mid-SHIFT
    adc_word = 12'hFFF;
    waitBusy(1100, "en_drop_start", n);
    repeat (20) @(negedge clock);
    enable = 1'b0;
    waitCsHigh(200, "en_drop_end");
    @(negedge clock);
    checkBit("en_drop_valid", data_valid, 1'b1);
    checkOutput("en_drop_sample", adcdata, 32'h00000FFF);
    idle_low = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      if (adc_cs_n !== 1'b1) idle_low++;
    end
    checkOutput("no_cs_after_disable", idle_low, 0);

    // Reset mid-SHIFT, with one sample still buffered
    adc_word = 12'h3C3;
    enable = 1'b1;
    waitBusy(1100, "rst_conv_start", n);
    checkOutput("restart_latency", n, 1000);
    repeat (30) @(negedge clock);
    reset = 1'b0;
    #1;
    checkBit("async_cs_n", adc_cs_n, 1'b1);
    checkBit("async_sclk", adc_sclk, 1'b0);
    checkBit("async_busy", busy, 1'b0);
    checkBit("async_valid", data_valid, 1'b0);
    checkOutput("async_adcdata", adcdata, 32'h0);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (150) @(negedge clock);
    checkBit("post_rst_no_push", data_valid, 1'b0);
    checkBit("post_rst_cs_n", adc_cs_n, 1'b1);
    checkBit("post_rst_ovr", overrun, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
